// File: rtl/pipe_pkg.sv
// Shared types and constants for the elastic pipeline stage register.
// The state enum is shared so sibling stages and benches agree on the encoding.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    localparam int unsigned PERF_CNT_W = 32;

    // EX/MEM control bit positions
    localparam int unsigned CTRL_MEM_TO_REG = 0;
    localparam int unsigned CTRL_MEM_WRITE  = 1;

endpackage

// File: rtl/pipe_sat_counter.sv
// Enabled up-counter that sticks at all-ones; async active-low reset.
module pipe_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with a two-entry skid buffer and registered in_ready.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble performance counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 16,
    parameter int unsigned CTRL_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_rd2,
    input  logic [DATA_W-1:0] in_alu,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_rd2,
    output logic [DATA_W-1:0] out_alu
`ifdef PIPE_STAGE_PERF_EN
   ,output logic [PERF_CNT_W-1:0] stall_cycles,
    output logic [PERF_CNT_W-1:0] bubble_cycles
`endif
);

    localparam int unsigned PAY_W = CTRL_W + PC_W + 2 * DATA_W;

    pipe_state_e      state_q, state_d;
    logic [PAY_W-1:0] main_q, main_d;
    logic [PAY_W-1:0] skid_q, skid_d;
    logic [PAY_W-1:0] in_pay;
    logic             in_ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic             accept;
    logic             fire;

    assign in_pay = {in_ctrl, in_pc, in_rd2, in_alu};
    assign accept = in_valid & in_ready_q;
    assign fire   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = BUSY;
                    main_d  = in_pay;
                end
            end
            BUSY: begin
                if (accept && fire) begin
                    main_d = in_pay;
                end else if (accept) begin
                    state_d = FULL;
                    skid_d  = in_pay;
                end else if (fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (fire) begin
                    state_d = BUSY;
                    main_d  = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Flush wins: drop any accept and leave the outputs showing the old payload.
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != EMPTY);
    assign {main_ctrl, out_pc, out_rd2, out_alu} = main_q;
    // Bubbles must never carry live write enables downstream.
    assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};

`ifdef PIPE_STAGE_PERF_EN
    pipe_sat_counter #(
        .WIDTH(PERF_CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (out_valid & ~out_ready),
        .count(stall_cycles)
    );

    pipe_sat_counter #(
        .WIDTH(PERF_CNT_W)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (~out_valid),
        .count(bubble_cycles)
    );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed bench for pipe_stage_reg against a two-slot FIFO model.
// Perf counter checks are active when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    typedef struct packed {
        logic [1:0]  ctrl;
        logic [15:0] pc;
        logic [31:0] rd2;
        logic [31:0] alu;
    } item_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_ctrl;
    logic [15:0] in_pc;
    logic [31:0] in_rd2;
    logic [31:0] in_alu;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_ctrl;
    logic [15:0] out_pc;
    logic [31:0] out_rd2;
    logic [31:0] out_alu;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif
    logic        sc_en;
    logic [3:0]  sc_count;

    pipe_stage_reg dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ctrl  (in_ctrl),
        .in_pc    (in_pc),
        .in_rd2   (in_rd2),
        .in_alu   (in_alu),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_ctrl (out_ctrl),
        .out_pc   (out_pc),
        .out_rd2  (out_rd2),
        .out_alu  (out_alu)
`ifdef PIPE_STAGE_PERF_EN
       ,.stall_cycles (stall_cycles),
        .bubble_cycles(bubble_cycles)
`endif
    );

    pipe_sat_counter #(
        .WIDTH(4)
    ) u_sc (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sc_en),
        .count(sc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a FIFO of capacity two whose ready flag is sampled at each edge.
    item_t q[$];
    item_t last_head;
    bit    m_ready;
    longint m_stall, m_bubble;
    int    total, passed, failed;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        item_t head;
        bit    v;
        v    = (q.size() > 0);
        head = v ? q[0] : last_head;
        check("out_valid", 64'(out_valid), 64'(v));
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("out_ctrl", 64'(out_ctrl), v ? 64'(head.ctrl) : 64'd0);
        check("out_pc", 64'(out_pc), 64'(head.pc));
        check("out_rd2", 64'(out_rd2), 64'(head.rd2));
        check("out_alu", 64'(out_alu), 64'(head.alu));
`ifdef PIPE_STAGE_PERF_EN
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        check("bubble_cycles", 64'(bubble_cycles), 64'(m_bubble));
`endif
    endtask

    // One clock cycle: drive, advance model and DUT, then compare.
    task automatic step(input bit v, input logic [1:0] c, input logic [15:0] pc,
                        input logic [31:0] rd2, input logic [31:0] alu,
                        input bit ordy, input bit fl);
        bit    acc, fir;
        item_t it;
        in_valid  = v;
        in_ctrl   = c;
        in_pc     = pc;
        in_rd2    = rd2;
        in_alu    = alu;
        out_ready = ordy;
        flush     = fl;
        it        = '{ctrl: c, pc: pc, rd2: rd2, alu: alu};
        acc       = v && m_ready;
        fir       = (q.size() > 0) && ordy;
        if (q.size() == 0) m_bubble++;
        else if (!ordy) m_stall++;
        @(posedge clk);
        if (fl) begin
            q.delete();
        end else begin
            if (fir) void'(q.pop_front());
            if (acc) q.push_back(it);
        end
        if (q.size() > 0) last_head = q[0];
        m_ready = (q.size() < 2);
        #1;
        check_outputs();
    endtask

    task automatic rand_step(input int flush_odds);
        step($urandom_range(0, 3) != 0, 2'($urandom), 16'($urandom), $urandom, $urandom,
             $urandom_range(0, 3) != 0, $urandom_range(0, flush_odds) == 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'b11;
        out_ready = 1'b1;
        flush     = 1'b0;
        q.delete();
        last_head = '0;
        m_ready   = 1'b0;
        m_stall   = 0;
        m_bubble  = 0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        failed = 0;
        sc_en  = 1'b0;
        rst_n  = 1'b1;
        #2;

        // Reset with in_valid high; in_ready rises one edge after release.
        do_reset();
        step(1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("ready_after_release", 64'(in_ready), 64'd1);

        // Back-to-back streaming.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'($urandom), 16'(i), $urandom, 32'h10 + 32'(i), 1'b1, 1'b0);
            check("stream_alu", 64'(out_alu), 64'h10 + 64'(i));
        end

        // Back-pressure for three cycles mid-stream.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 16'h100 + 16'(i), $urandom, 32'h20 + 32'(i), 1'b0, 1'b0);
        end
        check("full_in_ready", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        end

        // Fill to FULL, then flush with a live accept attempt.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b01, 16'h200, $urandom, 32'h30 + 32'(i), 1'b0, 1'b0);
        end
        step(1'b1, 2'b10, 16'h300, 32'h0, 32'h99, 1'b0, 1'b1);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ctrl", 64'(out_ctrl), 64'd0);
        check("flush_ready", 64'(in_ready), 64'd1);

        // Bubble gating: ctrl 2'b11 left in the main register while empty.
        step(1'b1, 2'b11, 16'h400, 32'h1, 32'h2, 1'b1, 1'b0);
        step(1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("bubble_ctrl", 64'(out_ctrl), 64'd0);

        for (int i = 0; i < 400; i++) rand_step(15);

        // Reset in the middle of traffic, then resume.
        do_reset();
        for (int i = 0; i < 200; i++) rand_step(31);

        // Saturating counter reaches all-ones and holds.
        sc_en = 1'b1;
        repeat (5) step(1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("sat_count_5", 64'(sc_count), 64'd5);
        repeat (15) step(1'b0, 2'b00, 16'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("sat_count_hold", 64'(sc_count), 64'hF);
        sc_en = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, elastic pipeline register for the processor datapath, used between any two stages (EX/MEM first, then ID/EX and MEM/WB). It carries a control field, PC, and two data words under a valid/ready handshake. A two-entry skid buffer provides full throughput with a registered `in_ready`. Synchronous flush turns the stage into a bubble, and control bits are zeroed whenever the output is not valid, so a bubble never writes memory or registers.

## Interface
Parameters:
- `DATA_W`, 32, width of each data word (`rd2`, `alu`)
- `PC_W`, 16, program-counter width
- `CTRL_W`, 2, control bit count (bit0 `mem_to_reg`, bit1 `mem_write` for EX/MEM)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `flush`  in  1  synchronous stage flush, highest priority
- `in_valid`  in  1  upstream payload valid
- `in_ready`  out  1  stage can accept; registered
- `in_ctrl`  in  `CTRL_W`  control bits
- `in_pc`  in  `PC_W`  PC
- `in_rd2`  in  `DATA_W`  store data
- `in_alu`  in  `DATA_W`  ALU result
- `out_valid`  out  1  downstream payload valid
- `out_ready`  in  1  downstream accepts
- `out_ctrl`  out  `CTRL_W`  control bits; forced to 0 when `out_valid`=0
- `out_pc`, `out_rd2`, `out_alu`  out  `PC_W`/`DATA_W`/`DATA_W`  payload
- `stall_cycles`, `bubble_cycles`  out  32  perf counters; present only with `PIPE_STAGE_PERF_EN`

## Operation
- Accept when `in_valid & in_ready`. Fire when `out_valid & out_ready`.
- Storage consists of a main register (drives the outputs) and a skid register.
- FSM states are EMPTY, BUSY (main only), and FULL (main and skid).
- EMPTY: accept → BUSY, main ← in.
- BUSY:
  - accept & fire → BUSY, main ← in.
  - accept & !fire → FULL, skid ← in.
  - fire & !accept → EMPTY.
  - otherwise hold.
- FULL: no accept is possible. Fire → BUSY, main ← skid. Otherwise hold.
- `out_valid` = state ≠ EMPTY. `out_ctrl` = main ctrl AND `out_valid`.
- Data outputs hold their last value in EMPTY. They are never X after reset.
- `flush` → EMPTY next edge, regardless of state. A same-cycle accept is discarded, and a same-cycle fire still counts as delivered.
- `in_ready` register ← (next state ≠ FULL). After a flush it is 1.
- Reset (`rst_n`=0, asynchronous):
  - State is EMPTY.
  - `in_ready`=0; it rises at the first `clk` edge after release.
  - `out_valid`=0, `out_ctrl`=0, `out_pc`=0, `out_rd2`=0, `out_alu`=0.
  - Counters are 0.
- Reset asserted mid-transfer drops all held payloads. No partial state survives.

## Timing
- Latency is 1 cycle from accept to `out_valid` when the stage is EMPTY or BUSY-with-fire.
- Throughput is 1 transfer per cycle with `out_ready` held high.
- Stall propagation: `out_ready` low for one cycle in BUSY with `in_valid` high → FULL. `in_ready` is 0 in the following cycle, so the upstream sees back-pressure one cycle late and the skid absorbs the in-flight word.
- No combinational path from `out_ready` to `in_ready`, or from inputs to outputs, except the `out_ctrl` valid gate.
- Ordering is strictly FIFO. No payload is lost or duplicated except by flush or reset.

## Configuration
- `PIPE_STAGE_PERF_EN` defined:
  - `stall_cycles` increments each cycle with `out_valid & !out_ready`.
  - `bubble_cycles` increments each cycle with `!out_valid`.
  - Both are 32-bit, saturate at all-ones, and are cleared only by reset (not by flush).
- Not defined: the counter ports and logic are absent, and behaviour is otherwise identical.

## Structure
- Shared package `pipe_pkg` holds:
  - the state enum `pipe_state_e` {EMPTY, BUSY, FULL};
  - `PERF_CNT_W` = 32;
  - EX/MEM control bit index constants `CTRL_MEM_TO_REG`=0 and `CTRL_MEM_WRITE`=1.
- Sub-module `pipe_sat_counter` (enable, 32-bit saturating, async active-low reset) is instantiated twice under the macro.
- The payload is packed internally as {ctrl, pc, rd2, alu} for the main and skid registers.

## Test plan
- Reset release: hold `rst_n`=0 with `in_valid`=1 → all outputs 0, `in_ready`=0. One edge after release, `in_ready`=1.
- Streaming: 8 back-to-back words with `alu`=0x10..0x17 and `out_ready`=1 → identical sequence on `out_alu`, one cycle later, with no gaps.
- Back-pressure: `out_ready`=0 for 3 cycles mid-stream → state reaches FULL and `in_ready`=0. After release, words are delivered in order with no loss or duplication.
- Flush in FULL with `in_valid`=1 and `in_ctrl`=2'b10 → next cycle `out_valid`=0 and `out_ctrl`=0, the accept is dropped, and `in_ready`=1.
- Bubble gating: EMPTY stage whose main register holds ctrl 2'b11 → `out_ctrl`=0 (`mem_write` never 1 while invalid).
- Perf (macro on): 5 stall cycles then 3 idle cycles → `stall_cycles`=5 and `bubble_cycles`≥3. Force saturation → counter holds at 0xFFFFFFFF.
